// File: rtl/rx_fifo.sv
// rx_fifo: receive-side frame queue behind the UART receiver.
// Stores {stop_err, parity_err, data} per frame in a circular buffer, serves
// a registered one-cycle-latency read port, tracks occupancy, flags overruns
// and optionally discards errored frames while counting them.

`ifndef DATA_WIDTH
  // uart_params.vh normally provides this; fall back to a byte when standalone.
  `define DATA_WIDTH 8
`endif

module rx_fifo #(
  parameter int  DATA_WIDTH   = `DATA_WIDTH,
  parameter int  DEPTH        = 16,
  parameter bit  DROP_ERRORED = 1'b0,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                  RX_CLK,
  input  logic                  RX_RST_N,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_PARITY_ERR,
  input  logic                  WR_STOP_ERR,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_PARITY_ERR,
  output logic                  RD_STOP_ERR,
  output logic                  RD_VALID,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [AW:0]           COUNT,
  output logic                  OVERRUN,
  input  logic                  OVERRUN_CLR,
  output logic [7:0]            DROP_CNT
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic                  stop_err;
    logic                  parity_err;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wp, rp;
  logic [AW:0]    count;

  logic errored, drop, rd_fire, accept, ovr_evt;

  assign COUNT = count;
  assign EMPTY = (count == '0);
  assign FULL  = (count == FULL_CNT);

  // Per-cycle event decode; a read frees a slot for a same-cycle write when full.
  always_comb begin
    errored = WR_PARITY_ERR | WR_STOP_ERR;
    drop    = WR_EN & DROP_ERRORED & errored;
    rd_fire = RD_EN & ~EMPTY;
    accept  = WR_EN & ~drop & (~FULL | rd_fire);
    ovr_evt = WR_EN & ~drop & FULL & ~rd_fire;
  end

  // Storage array; no reset needed, reads are gated by occupancy.
  always_ff @(posedge RX_CLK) begin
    if (RX_RST_N && accept)
      mem[wp] <= '{stop_err: WR_STOP_ERR, parity_err: WR_PARITY_ERR, data: WR_DATA};
  end

  // Pointers and occupancy.
  always_ff @(posedge RX_CLK) begin
    if (!RX_RST_N) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (accept)  wp <= wp + 1'b1;
      if (rd_fire) rp <= rp + 1'b1;
      if (accept && !rd_fire)      count <= count + 1'b1;
      else if (!accept && rd_fire) count <= count - 1'b1;
    end
  end

  // Registered read port; outputs hold when no read fires.
  always_ff @(posedge RX_CLK) begin
    if (!RX_RST_N) begin
      RD_DATA       <= '0;
      RD_PARITY_ERR <= 1'b0;
      RD_STOP_ERR   <= 1'b0;
      RD_VALID      <= 1'b0;
    end else begin
      RD_VALID <= rd_fire;
      if (rd_fire) begin
        RD_DATA       <= mem[rp].data;
        RD_PARITY_ERR <= mem[rp].parity_err;
        RD_STOP_ERR   <= mem[rp].stop_err;
      end
    end
  end

  // Sticky overrun (set beats clear) and saturating discard counter.
  always_ff @(posedge RX_CLK) begin
    if (!RX_RST_N) begin
      OVERRUN  <= 1'b0;
      DROP_CNT <= '0;
    end else begin
      if (ovr_evt)          OVERRUN <= 1'b1;
      else if (OVERRUN_CLR) OVERRUN <= 1'b0;
      if (drop && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: drives two rx_fifo instances (keep / drop errored frames) with
// shared stimulus and checks both every cycle against queue-based models.

module tb_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  typedef logic [DW+1:0] ent_t;   // {stop, parity, data}

  logic clk = 1'b0;
  logic rst_n, wr_en, wr_pe, wr_se, rd_en, ovr_clr;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] rd_data  [2];
  logic          rd_pe    [2];
  logic          rd_se    [2];
  logic          rd_valid [2];
  logic          empty    [2];
  logic          full     [2];
  logic [AW:0]   count    [2];
  logic          overrun  [2];
  logic [7:0]    drop_cnt [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_ERRORED(1'b0)) u_keep (
    .RX_CLK(clk), .RX_RST_N(rst_n), .WR_EN(wr_en), .WR_DATA(wr_data),
    .WR_PARITY_ERR(wr_pe), .WR_STOP_ERR(wr_se), .RD_EN(rd_en),
    .RD_DATA(rd_data[0]), .RD_PARITY_ERR(rd_pe[0]), .RD_STOP_ERR(rd_se[0]),
    .RD_VALID(rd_valid[0]), .EMPTY(empty[0]), .FULL(full[0]), .COUNT(count[0]),
    .OVERRUN(overrun[0]), .OVERRUN_CLR(ovr_clr), .DROP_CNT(drop_cnt[0]));

  rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_ERRORED(1'b1)) u_drop (
    .RX_CLK(clk), .RX_RST_N(rst_n), .WR_EN(wr_en), .WR_DATA(wr_data),
    .WR_PARITY_ERR(wr_pe), .WR_STOP_ERR(wr_se), .RD_EN(rd_en),
    .RD_DATA(rd_data[1]), .RD_PARITY_ERR(rd_pe[1]), .RD_STOP_ERR(rd_se[1]),
    .RD_VALID(rd_valid[1]), .EMPTY(empty[1]), .FULL(full[1]), .COUNT(count[1]),
    .OVERRUN(overrun[1]), .OVERRUN_CLR(ovr_clr), .DROP_CNT(drop_cnt[1]));

  // Reference model: a plain queue per instance plus flag/counter state.
  ent_t mq [2][$];
  ent_t m_rd  [2];
  bit   m_vld [2];
  bit   m_ovr [2];
  int   m_dc  [2];
  bit   started = 0;

  always @(posedge clk) begin
    bit drop;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mq[k].delete();
        m_rd[k] = '0; m_vld[k] = 0; m_ovr[k] = 0; m_dc[k] = 0;
      end else begin
        drop     = wr_en && (k == 1) && (wr_pe || wr_se);
        m_vld[k] = rd_en && (mq[k].size() != 0);
        if (m_vld[k]) m_rd[k] = mq[k].pop_front();
        if (ovr_clr) m_ovr[k] = 0;
        if (wr_en && !drop) begin
          if (mq[k].size() < DEPTH) mq[k].push_back({wr_se, wr_pe, wr_data});
          else m_ovr[k] = 1;
        end
        if (drop && m_dc[k] < 255) m_dc[k]++;
      end
    end
    if (!rst_n) started = 1;
  end

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] t=%0t got %0h want %0h", name, k, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk("rd_valid", k, rd_valid[k], m_vld[k]);
        chk("rd_data",  k, rd_data[k],  m_rd[k][DW-1:0]);
        chk("rd_par",   k, rd_pe[k],    m_rd[k][DW]);
        chk("rd_stop",  k, rd_se[k],    m_rd[k][DW+1]);
        chk("count",    k, count[k],    mq[k].size());
        chk("empty",    k, empty[k],    mq[k].size() == 0);
        chk("full",     k, full[k],     mq[k].size() == DEPTH);
        chk("overrun",  k, overrun[k],  m_ovr[k]);
        chk("drop_cnt", k, drop_cnt[k], m_dc[k]);
      end
    end
  end

  // One clock of stimulus; returns at the following negedge.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit pe, input bit se,
                     input bit r, input bit clr = 0, input bit rn = 1);
    wr_en = w; wr_data = d; wr_pe = pe; wr_se = se; rd_en = r; ovr_clr = clr; rst_n = rn;
    @(negedge clk);
    wr_en = 0; rd_en = 0; ovr_clr = 0; rst_n = 1;
  endtask

  task automatic drain(output logic [DW-1:0] last);
    int n = 0;
    last = '0;
    while (!(empty[0] && empty[1]) && n < 40) begin
      cyc(0, 0, 0, 0, 1);
      if (rd_valid[0]) last = rd_data[0];
      n++;
    end
    chk("drain_done", 0, empty[0] && empty[1], 1);
  endtask

  initial begin
    logic [DW-1:0] last;
    rst_n = 0; wr_en = 0; wr_data = 0; wr_pe = 0; wr_se = 0; rd_en = 0; ovr_clr = 0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 8'h55, 0, 0, 1, 0, 0);   // strobes during reset are ignored
    for (int k = 0; k < 2; k++) begin
      chk("rst_count", k, count[k], 0);
      chk("rst_empty", k, empty[k], 1);
      chk("rst_valid", k, rd_valid[k], 0);
    end

    // Three writes, three back-to-back reads.
    for (int i = 0; i < 3; i++) cyc(1, 8'h41 + 8'(i), 0, 0, 0);
    chk("cnt3", 0, count[0], 3);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("b2b_valid", 0, rd_valid[0], 1);
      chk("b2b_data",  0, rd_data[0], 8'h41 + 8'(i));
    end
    chk("cnt0", 0, count[0], 0);
    chk("empty0", 0, empty[0], 1);

    // Fill past full: 17th frame is lost.
    for (int i = 0; i < 17; i++) begin
      cyc(1, 8'(8'h20 + i), 0, 0, 0);
      if (i == 15) chk("full16", 0, full[0], 1);
    end
    chk("ovr_set", 0, overrun[0], 1);
    chk("cnt16", 0, count[0], 16);
    drain(last);
    chk("last_of_16", 0, last, 8'h2F);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ovr_clr", 0, overrun[0], 0);

    // Full plus simultaneous write/read.
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
    cyc(1, 8'h99, 0, 0, 1);
    chk("full_wr_rd_cnt", 0, count[0], 16);
    chk("full_wr_rd_ovr", 0, overrun[0], 0);
    drain(last);
    chk("last_99", 0, last, 8'h99);

    // Errored-frame filtering.
    cyc(1, 8'h10, 0, 0, 0);
    cyc(1, 8'h11, 1, 0, 0);
    cyc(1, 8'h12, 0, 1, 0);
    cyc(1, 8'h13, 0, 0, 0);
    chk("drop_cnt1", 1, count[1], 2);
    chk("drop_dc",   1, drop_cnt[1], 2);
    chk("keep_cnt",  0, count[0], 4);
    cyc(0, 0, 0, 0, 1);
    chk("drop_rd0", 1, rd_data[1], 8'h10);
    cyc(0, 0, 0, 0, 1);
    chk("drop_rd1", 1, rd_data[1], 8'h13);
    chk("keep_par", 0, rd_pe[0], 1);
    drain(last);

    // Empty with write and read together; then read on empty.
    cyc(1, 8'h77, 0, 0, 1);
    chk("emp_wr_rd_vld", 0, rd_valid[0], 0);
    chk("emp_wr_rd_cnt", 0, count[0], 1);
    drain(last);
    cyc(0, 0, 0, 0, 1);
    chk("rd_empty_vld", 0, rd_valid[0], 0);
    chk("rd_empty_hold", 0, rd_data[0], 8'h77);

    // Wrap: streaming write+read across the pointer wrap.
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'hA0 + i), 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, 8'(8'hB0 + i), 0, 0, 1);
    drain(last);
    chk("wrap_last", 0, last, 8'(8'hB0 + 39));

    // Discard counter saturation.
    for (int i = 0; i < 260; i++) cyc(1, 8'(i), 1, 0, 0);
    chk("dc_sat", 1, drop_cnt[1], 255);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-operation with five entries queued.
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0, 0, i == 4);
    chk("pre_rst_cnt", 0, count[0], 4);
    cyc(1, 8'hC5, 0, 0, 0);
    chk("pre_rst_cnt5", 0, count[0], 5);
    cyc(1, 8'hEE, 0, 0, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_cnt",  k, count[k], 0);
      chk("mid_rst_emp",  k, empty[k], 1);
      chk("mid_rst_data", k, rd_data[k], 0);
      chk("mid_rst_ovr",  k, overrun[k], 0);
      chk("mid_rst_dc",   k, drop_cnt[k], 0);
    end
    cyc(0, 0, 0, 0, 1);
    chk("post_rst_rd", 0, rd_valid[0], 0);

    // Randomized traffic with varying read pressure.
    for (int blk = 0; blk < 15; blk++) begin
      int rd_pct = $urandom_range(10, 90);
      for (int i = 0; i < 200; i++) begin
        cyc($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 99) < rd_pct,
            $urandom_range(0, 19) == 0, $urandom_range(0, 299) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_fifo.md
# rx_fifo

Receive-side frame buffer placed directly downstream of the UART receiver top. Each completed frame (data byte plus parity and stop error flags) is captured on a one-cycle write strobe and queued in a circular buffer. A host reads the queue through a registered read port. The block tracks occupancy, raises a sticky overrun flag when a frame arrives while full, and can optionally discard errored frames while counting them.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (from uart_params.vh): frame data width.
- `DEPTH`, default 16: number of entries; power of two, at least 2.
- `DROP_ERRORED`, default 0: when 1, frames with either error flag set are not stored.
- `AW`, default $clog2(DEPTH): pointer width (derived, not overridden).
- RX_CLK, input, 1: single clock. All logic is on the rising edge.
- RX_RST_N, input, 1: synchronous reset, active-low.
- WR_EN, input, 1: one-cycle strobe marking a completed received frame.
- WR_DATA, input, DATA_WIDTH: frame data from the receiver.
- WR_PARITY_ERR, input, 1: parity error flag for the frame.
- WR_STOP_ERR, input, 1: stop bit error flag for the frame.
- RD_EN, input, 1: host read request.
- RD_DATA, output, DATA_WIDTH: registered read data.
- RD_PARITY_ERR, output, 1: registered parity flag of the entry that was read.
- RD_STOP_ERR, output, 1: registered stop flag of the entry that was read.
- RD_VALID, output, 1: one-cycle pulse; the RD_* outputs are valid in that cycle.
- EMPTY, output, 1: COUNT == 0.
- FULL, output, 1: COUNT == DEPTH.
- COUNT, output, AW+1: current occupancy.
- OVERRUN, output, 1: sticky flag set when a frame was lost because the buffer was full.
- OVERRUN_CLR, input, 1: clears OVERRUN.
- DROP_CNT, output, 8: count of frames discarded as errored; saturates at 255.

## Operation
- Storage: DEPTH entries of {WR_STOP_ERR, WR_PARITY_ERR, WR_DATA}. Write pointer `wp` and read pointer `rp` are AW bits wide and wrap modulo DEPTH. COUNT is a separate register.
- A frame is errored when WR_PARITY_ERR | WR_STOP_ERR.
- Write accept: WR_EN & !(DROP_ERRORED & errored) & (!FULL | rd_fire). On accept, the entry is written at `wp` and `wp` increments.
- Discard: WR_EN & DROP_ERRORED & errored. Nothing is stored. DROP_CNT increments unless it is already 255.
- Overrun: WR_EN, frame not discarded, FULL, and no rd_fire. The frame is lost and OVERRUN is set to 1.
- Read: rd_fire = RD_EN & !EMPTY. On rd_fire, the entry at `rp` is loaded into the RD_* registers, RD_VALID is 1 next cycle, and `rp` increments.
- RD_EN while EMPTY is ignored: RD_VALID stays 0 and the RD_* outputs hold their previous values.
- COUNT update per cycle: +1 on accept only; -1 on rd_fire only; unchanged when both or neither occur.
- Simultaneous accept and rd_fire with COUNT == DEPTH: both proceed and COUNT stays at DEPTH. No overrun.
- Simultaneous WR_EN and RD_EN with COUNT == 0: the write is accepted, the read is ignored, and COUNT becomes 1.
- OVERRUN_CLR and an overrun event in the same cycle: set wins, so OVERRUN = 1.
- Reset (RX_RST_N low at a clock edge) clears everything below, whether idle or mid-operation. Memory contents need no reset.
  - wp, rp, COUNT → 0
  - EMPTY → 1, FULL → 0
  - RD_DATA, RD_PARITY_ERR, RD_STOP_ERR, RD_VALID → 0
  - OVERRUN → 0, DROP_CNT → 0
- Any WR_EN or RD_EN asserted in a reset cycle is ignored.

## Timing
- Write to readable: a frame written at edge N makes EMPTY = 0 after edge N. An RD_EN in cycle N+1 produces RD_VALID in cycle N+2.
- Read latency: 1 cycle from the RD_EN sample to RD_VALID/RD_DATA.
- Back-to-back RD_EN on every cycle drains one entry per cycle, giving continuous RD_VALID.
- Sustained throughput: one write and one read per cycle.
- EMPTY, FULL and COUNT are registered-derived and update after the same edge as the pointers.
- OVERRUN, DROP_CNT and OVERRUN_CLR take effect at the next edge.

## Test plan
- Reset, then 3 writes (0x41, 0x42, 0x43, no errors), then 3 consecutive RD_EN → RD_VALID in 3 consecutive cycles with data 0x41, 0x42, 0x43; COUNT returns to 0; EMPTY = 1.
- DEPTH=16: 17 writes with no reads → FULL = 1 after the 16th write; the 17th write is lost and OVERRUN = 1; draining returns the first 16 values in order. OVERRUN_CLR then clears it to 0.
- Full buffer with WR_EN=1 (data 0x99) and RD_EN=1 in the same cycle → no overrun; COUNT stays 16; after draining, 0x99 is the last entry read.
- DROP_ERRORED=1: write 0x10 (ok), 0x11 (parity err), 0x12 (stop err), 0x13 (ok) → COUNT = 2, DROP_CNT = 2, reads return 0x10 then 0x13. With DROP_ERRORED=0, all 4 are stored and the flags come back on RD_PARITY_ERR/RD_STOP_ERR.
- Empty buffer with WR_EN and RD_EN asserted together → no RD_VALID that cycle; COUNT = 1. Also: RD_EN with nothing queued → RD_VALID stays 0.
- Pointer wrap and reset: 40 interleaved write/read pairs across the wrap point → data order preserved. Then, with COUNT = 5, assert RX_RST_N = 0 for one cycle → COUNT = 0, EMPTY = 1, all outputs 0, and no RD_VALID on a subsequent RD_EN.
